// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_types_pkg                                                              |
// | Shared CPU types: RAM handshake state, word type and arbiter encodings.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        REISSUE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_I  = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } arb_src_t;

    localparam word_t BAD_LOAD = 32'hBAD1BAD1;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_select                                                                  |
// | Rotating-priority picker: first requesting core at or after the pointer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_select #(
    parameter int CPUS = 2,
    parameter int PW   = 1
) (
    input  logic [CPUS-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    logic [PW-1:0] w_cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        for (int k = 0; k < CPUS; k++) begin
            w_cand = PW'((int'(ptr_i) + k) % CPUS);
            if (!valid_o && req_i[w_cand]) begin
                valid_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Round-robin arbiter sharing one RAM port among per-core I/D request ports. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int RETRIES = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [CPUS*32-1:0] iaddr,
    output logic [CPUS-1:0]   iwait,
    output logic [CPUS*32-1:0] iload,
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [CPUS*32-1:0] daddr,
    input  logic [CPUS*32-1:0] dstore,
    output logic [CPUS-1:0]   dwait,
    output logic [CPUS*32-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_err
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int RW = $clog2(RETRIES + 2);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ISSUE   = ISSUE;
    localparam logic [1:0] ST_REISSUE = REISSUE;
    localparam logic [1:0] ST_DONE    = DONE;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [PW-1:0] core_q, core_d;
    arb_src_t      src_q, src_d;
    logic [RW-1:0] retry_q, retry_d;
    word_t         load_q, load_d;
    logic          err_q, err_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    word_t         addr_q, addr_d;
    word_t         store_q, store_d;

    word_t         w_iaddr  [CPUS];
    word_t         w_daddr  [CPUS];
    word_t         w_dstore [CPUS];
    logic [CPUS-1:0] w_req;
    logic [PW-1:0] w_sel;
    logic          w_sel_valid;

    generate
        for (genvar c = 0; c < CPUS; c++) begin : g_unpack
            assign w_iaddr[c]  = iaddr[c*32 +: 32];
            assign w_daddr[c]  = daddr[c*32 +: 32];
            assign w_dstore[c] = dstore[c*32 +: 32];
        end
    endgenerate

    assign w_req = iREN | dREN | dWEN;

    rr_select #(
        .CPUS (CPUS),
        .PW   (PW)
    ) u_rr_select (
        .req_i   (w_req),
        .ptr_i   (rr_q),
        .idx_o   (w_sel),
        .valid_o (w_sel_valid)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        core_d  = core_q;
        src_d   = src_q;
        retry_d = retry_q;
        load_d  = load_q;
        err_d   = err_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        store_d = store_q;

        case (state_q)
            ST_IDLE: begin
                addr_d  = '0;
                store_d = '0;
                if (w_sel_valid) begin
                    core_d  = w_sel;
                    state_d = ST_ISSUE;
                    // A simultaneous dREN/dWEN is served as the write.
                    if (dWEN[w_sel]) begin
                        src_d   = SRC_DW;
                        wen_d   = 1'b1;
                        addr_d  = w_daddr[w_sel];
                        store_d = w_dstore[w_sel];
                    end else if (dREN[w_sel]) begin
                        src_d   = SRC_DR;
                        ren_d   = 1'b1;
                        addr_d  = w_daddr[w_sel];
                    end else begin
                        src_d   = SRC_I;
                        ren_d   = 1'b1;
                        addr_d  = w_iaddr[w_sel];
                    end
                end
            end

            ST_ISSUE: begin
                ren_d = ren_q;
                wen_d = wen_q;
                if (ramstate == ACCESS) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    load_d  = (src_q == SRC_DW) ? '0 : ramload;
                    state_d = ST_DONE;
                end else if (ramstate == ERROR) begin
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                    if (retry_q < RW'(RETRIES)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_REISSUE;
                    end else begin
                        load_d  = BAD_LOAD;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_REISSUE: begin
                ren_d   = (src_q != SRC_DW);
                wen_d   = (src_q == SRC_DW);
                state_d = ST_ISSUE;
            end

            ST_DONE: begin
                rr_d    = (core_q == PW'(CPUS - 1)) ? '0 : core_q + PW'(1);
                retry_d = '0;
                addr_d  = '0;
                store_d = '0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            core_q  <= '0;
            src_q   <= SRC_I;
            retry_q <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            core_q  <= core_d;
            src_q   <= src_d;
            retry_q <= retry_d;
            load_q  <= load_d;
            err_q   <= err_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign arb_err  = err_q;

    // The live request line gates the pulse so a requester that gave up gets nothing.
    generate
        for (genvar c = 0; c < CPUS; c++) begin : g_fanout
            logic w_hit;
            logic w_i_ok;
            logic w_dr_ok;
            logic w_dw_ok;

            assign w_hit   = (state_q == ST_DONE) && (core_q == PW'(c));
            assign w_i_ok  = w_hit && (src_q == SRC_I)  && iREN[c];
            assign w_dr_ok = w_hit && (src_q == SRC_DR) && dREN[c];
            assign w_dw_ok = w_hit && (src_q == SRC_DW) && dWEN[c];

            assign iwait[c]          = !w_i_ok;
            assign iload[c*32 +: 32] = w_i_ok ? load_q : '0;
            assign dwait[c]          = !(w_dr_ok || w_dw_ok);
            assign dload[c*32 +: 32] = w_dr_ok ? load_q : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed self-checking bench for the two-core RAM port arbiter.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
    logic [63:0] iaddr, iload, daddr, dstore, dload;
    logic        ramREN, ramWEN, arb_err;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .CPUS    (2),
        .RETRIES (2)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .arb_err  (arb_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
        repeat (2) tick();
        n_checks++; if ({iwait, dwait} !== 4'b1111) begin n_fail++; $display("FAIL reset_waits: got %b expected 1111", {iwait, dwait}); end
        n_checks++; if ({iload, dload} !== 128'd0) begin n_fail++; $display("FAIL reset_loads: got %h expected 0", {iload, dload}); end
        n_checks++; if ({ramREN, ramWEN, arb_err} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {ramREN, ramWEN, arb_err}); end
        n_checks++; if ({ramaddr, ramstore} !== 64'd0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {ramaddr, ramstore}); end
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin n_fail++; $display("FAIL single_issue c%0d: got %b%b %h expected 10 00000040", k, ramREN, ramWEN, ramaddr); end
            n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL single_wait_hold c%0d: got %b expected 11", k, iwait); end
            ramstate = (k == 3) ? RS_ACCESS : RS_BUSY;
            ramload  = (k == 3) ? 32'h12345678 : 32'hFFFF0000;
        end
        tick();
        ramstate = RS_FREE;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL single_done_en: got %b expected 0", ramREN); end
        n_checks++; if ({iwait, dwait} !== 4'b1011) begin n_fail++; $display("FAIL single_done_wait: got %b expected 1011", {iwait, dwait}); end
        n_checks++; if (iload[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL single_iload: got %h expected 12345678", iload[31:0]); end
        iREN[0] = 1'b0;
        tick();
        n_checks++; if ({iwait, ramREN} !== 3'b110) begin n_fail++; $display("FAIL single_after: got %b expected 110", {iwait, ramREN}); end
    endtask

    task automatic test_priority();
        iREN[0] = 1'b1; dREN[0] = 1'b1; dWEN[0] = 1'b1;
        iaddr[31:0] = 32'h44; daddr[31:0] = 32'h80; dstore[31:0] = 32'hCAFE;
        tick();
        n_checks++; if ({ramREN, ramWEN} !== 2'b01) begin n_fail++; $display("FAIL prio_write_en: got %b expected 01", {ramREN, ramWEN}); end
        n_checks++; if ({ramaddr, ramstore} !== {32'h80, 32'hCAFE}) begin n_fail++; $display("FAIL prio_write_bus: got %h %h expected 00000080 0000cafe", ramaddr, ramstore); end
        ramstate = RS_ACCESS; ramload = 32'hDEADBEEF;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({iwait, dwait} !== 4'b1110) begin n_fail++; $display("FAIL prio_write_wait: got %b expected 1110", {iwait, dwait}); end
        n_checks++; if (dload !== 64'd0) begin n_fail++; $display("FAIL prio_write_load: got %h expected 0", dload); end
        dREN[0] = 1'b0; dWEN[0] = 1'b0;
        tick();
        tick();
        n_checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h44}) begin n_fail++; $display("FAIL prio_inst_issue: got %b%b %h expected 10 00000044", ramREN, ramWEN, ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h11112222;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({iwait, dwait, iload[31:0]} !== {4'b1011, 32'h11112222}) begin n_fail++; $display("FAIL prio_inst_done: got %b %h expected 1011 11112222", {iwait, dwait}, iload[31:0]); end
        iREN[0] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic [1:0]  exp_wait;
        int          core;
        dREN = 2'b11; daddr = {32'h200, 32'h100};
        // Core 0 was served last, so core 1 leads.
        for (int g = 0; g < 4; g++) begin
            core     = (g % 2 == 0) ? 1 : 0;
            exp_addr = (core == 1) ? 32'h200 : 32'h100;
            exp_wait = (core == 1) ? 2'b01 : 2'b10;
            tick();
            n_checks++; if ({ramREN, ramaddr} !== {1'b1, exp_addr}) begin n_fail++; $display("FAIL rr_issue g%0d: got %b %h expected 1 %h", g, ramREN, ramaddr, exp_addr); end
            ramstate = RS_ACCESS; ramload = 32'hA0000000 + 32'(g);
            tick();
            ramstate = RS_FREE;
            n_checks++; if (dwait !== exp_wait) begin n_fail++; $display("FAIL rr_wait g%0d: got %b expected %b", g, dwait, exp_wait); end
            n_checks++; if (dload[core*32 +: 32] !== 32'hA0000000 + 32'(g)) begin n_fail++; $display("FAIL rr_load g%0d: got %h expected %h", g, dload[core*32 +: 32], 32'hA0000000 + 32'(g)); end
            tick();
        end
        dREN = 2'b00;
    endtask

    task automatic test_error_retry();
        dREN[1] = 1'b1; daddr[63:32] = 32'h300;
        for (int e = 0; e < 2; e++) begin
            tick();
            n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL retry_issue e%0d: got %b expected 1", e, ramREN); end
            ramstate = RS_ERROR;
            tick();
            ramstate = RS_FREE;
            n_checks++; if ({ramREN, dwait} !== 3'b011) begin n_fail++; $display("FAIL retry_gap e%0d: got %b expected 011", e, {ramREN, dwait}); end
        end
        tick();
        n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL retry_final_issue: got %b %h expected 1 00000300", ramREN, ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h5555AAAA;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({dwait, dload[63:32], arb_err} !== {2'b01, 32'h5555AAAA, 1'b0}) begin n_fail++; $display("FAIL retry_done: got %b %h %b expected 01 5555aaaa 0", dwait, dload[63:32], arb_err); end
        dREN[1] = 1'b0;
        tick();
    endtask

    task automatic test_error_exhaust();
        dREN[0] = 1'b1; daddr[31:0] = 32'h400;
        for (int e = 0; e < 2; e++) begin
            tick();
            ramstate = RS_ERROR;
            tick();
            ramstate = RS_FREE;
            n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL exhaust_gap e%0d: got %b expected 0", e, ramREN); end
        end
        tick();
        ramstate = RS_ERROR; ramload = 32'h77777777;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({dwait, dload[31:0]} !== {2'b10, 32'hBAD1BAD1}) begin n_fail++; $display("FAIL exhaust_done: got %b %h expected 10 bad1bad1", dwait, dload[31:0]); end
        n_checks++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL exhaust_err: got %b expected 1", arb_err); end
        dREN[0] = 1'b0;
        repeat (3) tick();
        n_checks++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL exhaust_sticky: got %b expected 1", arb_err); end
    endtask

    task automatic test_reset_and_drop();
        iREN[0] = 1'b1; iaddr[31:0] = 32'h500;
        tick();
        ramstate = RS_BUSY;
        n_checks++; if ({ramREN, arb_err} !== 2'b11) begin n_fail++; $display("FAIL midreset_pre: got %b expected 11", {ramREN, arb_err}); end
        nRST = 1'b0; iREN = '0;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({iwait, dwait, ramREN, ramWEN, arb_err} !== 7'b1111000) begin n_fail++; $display("FAIL midreset_state: got %b expected 1111000", {iwait, dwait, ramREN, ramWEN, arb_err}); end
        nRST = 1'b1;
        // Pointer is back at 0, so core 0 wins even though core 1 is next after the last grant.
        dREN = 2'b11; daddr = {32'h700, 32'h600};
        tick();
        n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h600}) begin n_fail++; $display("FAIL midreset_rr: got %b %h expected 1 00000600", ramREN, ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h66666666;
        tick();
        ramstate = RS_FREE;
        n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL midreset_done: got %b expected 10", dwait); end
        dREN[0] = 1'b0;
        tick();
        tick();
        n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h700}) begin n_fail++; $display("FAIL drop_issue: got %b %h expected 1 00000700", ramREN, ramaddr); end
        ramstate = RS_BUSY; dREN[1] = 1'b0;
        tick();
        ramstate = RS_ACCESS; ramload = 32'h99999999;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({iwait, dwait, dload} !== {4'b1111, 64'd0}) begin n_fail++; $display("FAIL drop_no_pulse: got %b %h expected 1111 0", {iwait, dwait}, dload); end
        tick();
        iREN[0] = 1'b1; iaddr[31:0] = 32'h800;
        tick();
        n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL drop_next_issue: got %b %h expected 1 00000800", ramREN, ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h13572468;
        tick();
        ramstate = RS_FREE;
        n_checks++; if ({iwait, iload[31:0]} !== {2'b10, 32'h13572468}) begin n_fail++; $display("FAIL drop_next_done: got %b %h expected 10 13572468", iwait, iload[31:0]); end
        iREN[0] = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_error_retry();
        test_error_exhaust();
        test_reset_and_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction and data request streams of both cores in the dual-core design.
- Sits between the per-core cache/request-unit outputs (iREN, dREN, dWEN) and the RAM model.
- Grants one source at a time, sequences the RAM transaction to completion, and returns the wait/load handshake to the granted source.
- Arbitration is round-robin across cores; within a core, data has priority over instruction.

Parameters:
- CPUS, 2, number of cores sharing the port (1..4)
- RETRIES, 2, number of re-issues after a RAM ERROR before the access is forced complete

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- iREN  in  CPUS  instruction read request per core
- iaddr  in  CPUS*32  instruction address per core (word_t slices)
- iwait  out  CPUS  instruction wait per core, high = not done
- iload  out  CPUS*32  instruction data per core
- dREN  in  CPUS  data read request per core
- dWEN  in  CPUS  data write request per core
- daddr  in  CPUS*32  data address per core
- dstore  in  CPUS*32  data store value per core
- dwait  out  CPUS  data wait per core
- dload  out  CPUS*32  data read value per core
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- arb_err  out  1  sticky; set when an access exhausts its retries

Behaviour:
- Reset (nRST low at a CLK edge):
  - state IDLE, rr pointer 0, retry count 0.
  - ramREN, ramWEN, ramaddr, ramstore all 0.
  - all iwait and dwait 1; all iload and dload 0; arb_err 0.
  - Reset mid-transaction abandons the access with no wait pulse.
- Source selection:
  - Candidate cores are those with any of iREN, dREN or dWEN high.
  - Scan starts at the rr pointer, ascending with wrap.
  - In the chosen core, dWEN beats dREN beats iREN.
  - dWEN and dREN both high is treated as a write.
- IDLE:
  - On any request, register the grant (core, source) plus its address and store data; go to ISSUE.
  - No request: remain in IDLE; RAM outputs stay 0.
- ISSUE:
  - Drive ramREN or ramWEN with the latched address/data.
  - Hold until ramstate observes ACCESS or ERROR; FREE and BUSY both mean wait.
  - ACCESS: latch ramload; go to DONE.
  - ERROR with retry count < RETRIES: increment the count, deassert enables for one cycle (REISSUE), then return to ISSUE.
  - ERROR with retries exhausted: latch 32'hBAD1BAD1, set arb_err, go to DONE.
- DONE (exactly one cycle):
  - Enables are 0.
  - The granted source's wait is low and its load shows the latched value. Writes show load 0.
  - If the granted request line has dropped by this cycle, no wait pulse is given and the result is discarded.
  - Set rr = (granted core + 1) mod CPUS; clear the retry count; go to IDLE.
  - A new grant can issue no earlier than the cycle after DONE.
- Latency: request seen in IDLE at cycle 0 → enables high at cycle 1 → ACCESS at cycle k → wait low at cycle k+1.
- All outputs are registered except the per-source wait/load fan-out, which decodes the registered grant and DONE flag.
- Requesters must hold request, address and data until their wait goes low. Changes in the meantime are ignored because the values are latched.
- Only one wait output is ever low per cycle.
- A request that arrives while another is in service is not lost; it is serviced in a later IDLE.
- arb_err clears only on reset.

Decomposition:
- cpu_types_pkg adds:
  - arb_state_t {IDLE, ISSUE, REISSUE, DONE}
  - arb_src_t {SRC_I, SRC_DR, SRC_DW}
  - BAD_LOAD = 32'hBAD1BAD1
- ramstate_t and word_t are reused from cpu_types_pkg.
- Sub-module rr_select: combinational rotate-priority picker.
  - Inputs: request mask[CPUS], rr pointer.
  - Outputs: grant index, valid.
  - Instanced once.

Test Plan:
- Single read:
  - Stimulus: core0 iREN=1, iaddr=0x40; RAM returns ACCESS after 3 BUSY cycles with ramload=0x12345678.
  - Required: ramREN high for 4 cycles; iwait[0] low for exactly one cycle with iload[0]=0x12345678.
- Intra-core priority:
  - Stimulus: core0 iREN, dREN and dWEN all high, dstore=0xCAFE.
  - Required: the write is served first (ramWEN=1, ramstore=0xCAFE); dwait[0] pulses; iREN is served on the next grant.
- Round-robin:
  - Stimulus: core0 and core1 hold dREN continuously.
  - Required: grants alternate 0,1,0,1; no core is served twice in a row.
- Error retry:
  - Stimulus: RETRIES=2; RAM gives ERROR, ERROR, ACCESS.
  - Required: ramREN drops for one cycle after each ERROR; the access completes with real data; arb_err=0.
- Error exhaustion:
  - Stimulus: RAM gives ERROR three times.
  - Required: dload=0xBAD1BAD1 with a dwait pulse; arb_err=1 and stays 1 until nRST.
- Reset and dropped request:
  - Stimulus: assert nRST low during ISSUE. Separately, deassert dREN before ACCESS.
  - Required: after reset all waits=1, enables=0, rr=0. For the dropped request, no dwait pulse and the next grant proceeds normally.
